// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle cpu_core: instruction fields, opcodes,
// condition codes, FSM encoding and opcode classification helpers.
package cpu_pkg;

    localparam int COND_MSB = 31;
    localparam int COND_LSB = 28;
    localparam int OP_MSB   = 27;
    localparam int OP_LSB   = 24;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 20;
    localparam int SEL1_MSB = 19;
    localparam int SEL1_LSB = 16;
    localparam int SEL2_MSB = 15;
    localparam int SEL2_LSB = 12;
    localparam int IMM_MSB  = 11;
    localparam int IMM_LSB  = 0;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_LSL   = 4'h6,
        OP_LSR   = 4'h7,
        OP_MOV   = 4'h8,
        OP_MOVI  = 4'h9,
        OP_LOAD  = 4'hA,
        OP_STORE = 4'hB,
        OP_CMP   = 4'hC,
        OP_B     = 4'hD,
        OP_NOP   = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    // Condition codes 9..F are reserved and never execute.
    localparam logic [3:0] CC_AL = 4'h0;
    localparam logic [3:0] CC_EQ = 4'h1;
    localparam logic [3:0] CC_NE = 4'h2;
    localparam logic [3:0] CC_CS = 4'h3;
    localparam logic [3:0] CC_CC = 4'h4;
    localparam logic [3:0] CC_MI = 4'h5;
    localparam logic [3:0] CC_PL = 4'h6;
    localparam logic [3:0] CC_VS = 4'h7;
    localparam logic [3:0] CC_VC = 4'h8;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    function automatic logic writes_reg(input opcode_t op);
        logic w;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_LSL, OP_LSR, OP_MOV, OP_MOVI, OP_LOAD: w = 1'b1;
            default:                                   w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic updates_flags(input opcode_t op);
        logic u;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_LSL, OP_LSR, OP_CMP: u = 1'b1;
            default:                u = 1'b0;
        endcase
        return u;
    endfunction

    // Logical ops refresh only N and Z; C and V carry over.
    function automatic logic is_logical(input opcode_t op);
        logic l;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR: l = 1'b1;
            default:                                       l = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic, logic, shifts and operand pass-through, with
// NZCV computed from the result.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic    [31:0] a,
    input  logic    [31:0] b,
    input  opcode_t        op,
    output logic    [31:0] result,
    output logic    [3:0]  nzcv
);

    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic        carry_s;
    logic        ovf_s;

    // Subtraction as a + ~b + 1 so that the carry out is the no-borrow flag.
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} + {1'b0, ~b} + 33'd1;

    // Result and raw carry/overflow selection per opcode
    always_comb begin
        result  = 32'd0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op)
            OP_ADD, OP_LOAD, OP_STORE: begin
                result  = sum_s[31:0];
                carry_s = sum_s[32];
                ovf_s   = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            OP_SUB, OP_CMP: begin
                result  = diff_s[31:0];
                carry_s = diff_s[32];
                ovf_s   = (a[31] != b[31]) && (diff_s[31] != a[31]);
            end
            OP_AND:          result = a & b;
            OP_OR:           result = a | b;
            OP_XOR:          result = a ^ b;
            OP_NOT:          result = ~a;
            OP_LSL:          result = a << b[4:0];
            OP_LSR:          result = a >> b[4:0];
            OP_MOV, OP_MOVI: result = b;
            default:         result = 32'd0;
        endcase
    end

    assign nzcv = {result[31], (result == 32'd0), carry_s, ovf_s};

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle conditional load/store CPU: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// sequencing, register file, condition check and internal ROM/RAM.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int ROM_DEPTH = 256,
    parameter int RAM_DEPTH = 16,
    parameter int DATA_W    = 32
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] pc_out,
    output logic [2:0] state_out,
    output logic [3:0] flags_out
);

    state_t              current_state;
    logic [7:0]          pc;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   source1;
    logic [DATA_W-1:0]   source2;
    logic [DATA_W-1:0]   ALU_data;
    logic [DATA_W-1:0]   load_data_r;
    logic [3:0]          flags;
    logic [3:0]          alu_flags_r;
    logic                execute;
    logic [DATA_W-1:0]   regs_r [16];

    opcode_t             opcode;
    logic [3:0]          cond;
    logic [3:0]          select1;
    logic [3:0]          select2;
    logic [3:0]          dest;
    logic [DATA_W-1:0]   imm_s;
    logic [DATA_W-1:0]   alu_b_s;
    logic [DATA_W-1:0]   alu_result_s;
    logic [3:0]          alu_nzcv_s;
    logic [DATA_W-1:0]   rom_data_s;
    logic [DATA_W-1:0]   ram_rd_s;
    logic [3:0]          ram_addr_s;
    logic                ram_we_s;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic p;
        case (c)
            CC_AL:   p = 1'b1;
            CC_EQ:   p = f[FLAG_Z];
            CC_NE:   p = ~f[FLAG_Z];
            CC_CS:   p = f[FLAG_C];
            CC_CC:   p = ~f[FLAG_C];
            CC_MI:   p = f[FLAG_N];
            CC_PL:   p = ~f[FLAG_N];
            CC_VS:   p = f[FLAG_V];
            CC_VC:   p = ~f[FLAG_V];
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    assign cond    = ir[COND_MSB:COND_LSB];
    assign opcode  = opcode_t'(ir[OP_MSB:OP_LSB]);
    assign dest    = ir[DEST_MSB:DEST_LSB];
    assign select1 = ir[SEL1_MSB:SEL1_LSB];
    assign select2 = ir[SEL2_MSB:SEL2_LSB];
    assign imm_s   = {{(DATA_W-12){1'b0}}, ir[IMM_MSB:IMM_LSB]};

    assign pc_out    = pc;
    assign state_out = current_state;
    assign flags_out = flags;

    // Second ALU operand: immediate for MOVI and address arithmetic, else source2
    always_comb begin
        alu_b_s = source2;
        case (opcode)
            OP_MOVI, OP_LOAD, OP_STORE: alu_b_s = imm_s;
            default:                    alu_b_s = source2;
        endcase
    end

    cpu_alu u_alu (
        .a      (source1),
        .b      (alu_b_s),
        .op     (opcode),
        .result (alu_result_s),
        .nzcv   (alu_nzcv_s)
    );

    assign ram_addr_s = ALU_data[3:0];
    // Gating with reset keeps a STORE caught by reset from landing.
    assign ram_we_s   = (current_state == S_MEM) && execute && (opcode == OP_STORE) && !reset;

    if (ROM_DEPTH > 0) begin : rom
        logic [DATA_W-1:0] mem [ROM_DEPTH];
        assign rom_data_s = mem[pc];
    end

    if (RAM_DEPTH > 0) begin : ram
        logic [DATA_W-1:0] mem [RAM_DEPTH];
        assign ram_rd_s = mem[ram_addr_s];

        // Synchronous data RAM write during MEM of an executed STORE
        always_ff @(posedge clock) begin
            if (ram_we_s) begin
                mem[ram_addr_s] <= source2;
            end else begin
                mem[ram_addr_s] <= mem[ram_addr_s];
            end
        end
    end

    // Register file: cleared by reset, written in WRITEBACK of executed writers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if ((current_state == S_WRITEBACK) && execute && writes_reg(opcode)) begin
            regs_r[dest] <= (opcode == OP_LOAD) ? load_data_r : ALU_data;
        end
    end

    // Instruction sequencer with datapath registers, flags and pc
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            current_state <= S_FETCH;
            pc            <= 8'd0;
            ir            <= 32'd0;
            source1       <= 32'd0;
            source2       <= 32'd0;
            ALU_data      <= 32'd0;
            load_data_r   <= 32'd0;
            alu_flags_r   <= 4'd0;
            flags         <= 4'd0;
            execute       <= 1'b0;
        end else begin
            case (current_state)
                S_FETCH: begin
                    ir            <= rom_data_s;
                    current_state <= S_DECODE;
                end
                S_DECODE: begin
                    source1       <= regs_r[select1];
                    source2       <= regs_r[select2];
                    execute       <= cond_pass(cond, flags);
                    current_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    ALU_data      <= alu_result_s;
                    alu_flags_r   <= alu_nzcv_s;
                    current_state <= S_MEM;
                end
                S_MEM: begin
                    if (execute && (opcode == OP_LOAD)) begin
                        load_data_r <= ram_rd_s;
                    end
                    current_state <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (execute && updates_flags(opcode)) begin
                        if (is_logical(opcode)) begin
                            flags <= {alu_flags_r[FLAG_N], alu_flags_r[FLAG_Z],
                                      flags[FLAG_C], flags[FLAG_V]};
                        end else begin
                            flags <= alu_flags_r;
                        end
                    end
                    if (execute && (opcode == OP_HALT)) begin
                        current_state <= S_HALT;
                    end else if (execute && (opcode == OP_B)) begin
                        pc            <= ir[7:0];
                        current_state <= S_FETCH;
                    end else begin
                        pc            <= pc + 8'd1;
                        current_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    current_state <= S_HALT;
                end
                default: begin
                    current_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: programs are loaded into ROM, expected retire
// results are queued, and a monitor checks each retirement against the queue.
module tb_cpu_core;

    logic       clock;
    logic       reset;
    logic [7:0] pc_out;
    logic [2:0] state_out;
    logic [3:0] flags_out;

    int checks   = 0;
    int failures = 0;
    int ret_idx  = 0;
    bit mon_en   = 1'b0;
    logic [2:0] prev_state = 3'd0;

    typedef struct {
        logic [7:0]  pc;
        logic [3:0]  fl;
        logic        ex;
        logic [3:0]  ri;
        logic [31:0] rv;
        logic        halt;
    } exp_t;

    exp_t exp_q[$];

    cpu_core dut (
        .clock     (clock),
        .reset     (reset),
        .pc_out    (pc_out),
        .state_out (state_out),
        .flags_out (flags_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] enc(input logic [3:0] c, input logic [3:0] op,
                                        input logic [3:0] d, input logic [3:0] s1,
                                        input logic [3:0] s2, input logic [11:0] imm);
        return {c, op, d, s1, s2, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [3:0] f, input logic ex,
                        input logic [3:0] ri, input logic [31:0] rv, input logic h);
        exp_t e;
        e.pc = p; e.fl = f; e.ex = ex; e.ri = ri; e.rv = rv; e.halt = h;
        exp_q.push_back(e);
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) dut.rom.mem[i] = enc(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 12'h000);
    endtask

    task automatic load_prog1();
        fill_rom();
        for (int i = 0; i < 16; i++) dut.ram.mem[i] = 32'd0;
        dut.ram.mem[2] = 32'hDEADBEEF;
        dut.rom.mem[0]  = enc(4'h0, 4'h9, 4'd1,  4'd0,  4'd0,  12'd5);   push(8'd1,  4'b0000, 1'b1, 4'd1,  32'd5, 1'b0);
        dut.rom.mem[1]  = enc(4'h0, 4'h9, 4'd2,  4'd0,  4'd0,  12'd3);   push(8'd2,  4'b0000, 1'b1, 4'd2,  32'd3, 1'b0);
        dut.rom.mem[2]  = enc(4'h0, 4'h0, 4'd3,  4'd1,  4'd2,  12'd0);   push(8'd3,  4'b0000, 1'b1, 4'd3,  32'd8, 1'b0);
        dut.rom.mem[3]  = enc(4'h0, 4'hC, 4'd0,  4'd1,  4'd1,  12'd0);   push(8'd4,  4'b0110, 1'b1, 4'd0,  32'd0, 1'b0);
        dut.rom.mem[4]  = enc(4'h2, 4'h9, 4'd4,  4'd0,  4'd0,  12'd7);   push(8'd5,  4'b0110, 1'b0, 4'd4,  32'd0, 1'b0);
        dut.rom.mem[5]  = enc(4'h0, 4'hA, 4'd5,  4'd0,  4'd0,  12'd2);   push(8'd6,  4'b0110, 1'b1, 4'd5,  32'hDEADBEEF, 1'b0);
        dut.rom.mem[6]  = enc(4'h0, 4'hB, 4'd0,  4'd0,  4'd5,  12'd15);  push(8'd7,  4'b0110, 1'b1, 4'd5,  32'hDEADBEEF, 1'b0);
        dut.rom.mem[7]  = enc(4'h0, 4'h6, 4'd10, 4'd5,  4'd1,  12'd0);   push(8'd8,  4'b1010, 1'b1, 4'd10, 32'hD5B7DDE0, 1'b0);
        dut.rom.mem[8]  = enc(4'h0, 4'h7, 4'd11, 4'd5,  4'd2,  12'd0);   push(8'd9,  4'b0010, 1'b1, 4'd11, 32'h1BD5B7DD, 1'b0);
        dut.rom.mem[9]  = enc(4'h0, 4'h4, 4'd12, 4'd5,  4'd5,  12'd0);   push(8'd10, 4'b0110, 1'b1, 4'd12, 32'd0, 1'b0);
        dut.rom.mem[10] = enc(4'h0, 4'h5, 4'd13, 4'd0,  4'd0,  12'd0);   push(8'd11, 4'b1010, 1'b1, 4'd13, 32'hFFFFFFFF, 1'b0);
        dut.rom.mem[11] = enc(4'h0, 4'h3, 4'd14, 4'd1,  4'd2,  12'd0);   push(8'd12, 4'b0010, 1'b1, 4'd14, 32'd7, 1'b0);
        dut.rom.mem[12] = enc(4'h0, 4'h2, 4'd15, 4'd1,  4'd2,  12'd0);   push(8'd13, 4'b0010, 1'b1, 4'd15, 32'd1, 1'b0);
        dut.rom.mem[13] = enc(4'h0, 4'h7, 4'd14, 4'd13, 4'd15, 12'd0);   push(8'd14, 4'b0010, 1'b1, 4'd14, 32'h7FFFFFFF, 1'b0);
        dut.rom.mem[14] = enc(4'h0, 4'h0, 4'd14, 4'd14, 4'd15, 12'd0);   push(8'd15, 4'b1001, 1'b1, 4'd14, 32'h80000000, 1'b0);
        dut.rom.mem[15] = enc(4'h7, 4'h9, 4'd8,  4'd0,  4'd0,  12'h123); push(8'd16, 4'b1001, 1'b1, 4'd8,  32'h123, 1'b0);
        dut.rom.mem[16] = enc(4'h1, 4'h9, 4'd9,  4'd0,  4'd0,  12'd1);   push(8'd17, 4'b1001, 1'b0, 4'd9,  32'd0, 1'b0);
        dut.rom.mem[17] = enc(4'h0, 4'h8, 4'd7,  4'd0,  4'd3,  12'd0);   push(8'd18, 4'b1001, 1'b1, 4'd7,  32'd8, 1'b0);
        dut.rom.mem[18] = enc(4'h0, 4'hF, 4'd0,  4'd0,  4'd0,  12'd0);   push(8'd18, 4'b1001, 1'b1, 4'd7,  32'd8, 1'b1);
    endtask

    task automatic load_prog2(input bit with_exp);
        fill_rom();
        dut.rom.mem[0] = enc(4'h0, 4'h9, 4'd6, 4'd0, 4'd0, 12'd1);
        dut.rom.mem[1] = enc(4'h0, 4'h9, 4'd1, 4'd0, 4'd0, 12'd0);
        dut.rom.mem[2] = enc(4'h0, 4'h1, 4'd2, 4'd1, 4'd6, 12'd0);
        dut.rom.mem[3] = enc(4'h0, 4'h0, 4'd9, 4'd9, 4'd6, 12'd0);
        dut.rom.mem[4] = enc(4'h0, 4'hC, 4'd0, 4'd9, 4'd6, 12'd0);
        dut.rom.mem[5] = enc(4'h2, 4'hF, 4'd0, 4'd0, 4'd0, 12'd0);
        dut.rom.mem[6] = enc(4'h0, 4'hE, 4'd0, 4'd0, 4'd0, 12'd0);
        dut.rom.mem[7] = enc(4'h0, 4'hD, 4'd0, 4'd0, 4'd0, 12'd0);
        if (with_exp) begin
            push(8'd1, 4'b0000, 1'b1, 4'd6, 32'd1, 1'b0);
            push(8'd2, 4'b0000, 1'b1, 4'd1, 32'd0, 1'b0);
            push(8'd3, 4'b1000, 1'b1, 4'd2, 32'hFFFFFFFF, 1'b0);
            push(8'd4, 4'b0000, 1'b1, 4'd9, 32'd1, 1'b0);
            push(8'd5, 4'b0110, 1'b1, 4'd9, 32'd1, 1'b0);
            push(8'd6, 4'b0110, 1'b0, 4'd9, 32'd1, 1'b0);
            push(8'd7, 4'b0110, 1'b1, 4'd9, 32'd1, 1'b0);
            push(8'd0, 4'b0110, 1'b1, 4'd9, 32'd1, 1'b0);
            push(8'd1, 4'b0110, 1'b1, 4'd6, 32'd1, 1'b0);
            push(8'd2, 4'b0110, 1'b1, 4'd1, 32'd0, 1'b0);
            push(8'd3, 4'b1000, 1'b1, 4'd2, 32'hFFFFFFFF, 1'b0);
            push(8'd4, 4'b0000, 1'b1, 4'd9, 32'd2, 1'b0);
            push(8'd5, 4'b0010, 1'b1, 4'd9, 32'd2, 1'b0);
            push(8'd5, 4'b0010, 1'b1, 4'd9, 32'd2, 1'b1);
        end
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d retirements outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_halt(input string name, input logic [7:0] hpc);
        for (int k = 0; k < 4; k++) begin
            repeat (5) @(negedge clock);
            chk($sformatf("%s_state_%0d", name, k), {29'd0, state_out}, 32'd5);
            chk($sformatf("%s_pc_%0d", name, k), {24'd0, pc_out}, {24'd0, hpc});
        end
    endtask

    // Retirement monitor: WRITEBACK just finished when the state leaves 4
    always @(negedge clock) begin
        exp_t e;
        if (mon_en && prev_state == 3'd4 && state_out != 3'd4) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL retire_unexpected: got retire at pc=%0d expected none", pc_out);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("ret%0d_pc", ret_idx), {24'd0, pc_out}, {24'd0, e.pc});
                chk($sformatf("ret%0d_flags", ret_idx), {28'd0, flags_out}, {28'd0, e.fl});
                chk($sformatf("ret%0d_execute", ret_idx), {31'd0, dut.execute}, {31'd0, e.ex});
                chk($sformatf("ret%0d_r%0d", ret_idx, e.ri), dut.regs_r[e.ri], e.rv);
                chk($sformatf("ret%0d_state", ret_idx), {29'd0, state_out}, e.halt ? 32'd5 : 32'd0);
            end
            ret_idx++;
        end
        prev_state = state_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        load_prog1();
        repeat (2) @(negedge clock);
        chk("reset_pc", {24'd0, pc_out}, 32'd0);
        chk("reset_state", {29'd0, state_out}, 32'd0);
        chk("reset_flags", {28'd0, flags_out}, 32'd0);
        mon_en = 1'b1;
        reset  = 1'b0;
        wait_drain("prog1", 300);
        check_halt("prog1_halt", 8'd18);
        chk("ram15_store", dut.ram.mem[15], 32'hDEADBEEF);
        chk("ram2_kept", dut.ram.mem[2], 32'hDEADBEEF);

        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        load_prog2(1'b1);
        mon_en = 1'b1;
        reset  = 1'b0;
        wait_drain("prog2", 300);
        check_halt("prog2_halt", 8'd5);

        // Asynchronous reset in the middle of an EXECUTE cycle
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        load_prog2(1'b0);
        reset = 1'b0;
        n = 0;
        while (!(state_out == 3'd2 && pc_out == 8'd3) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("pre_reset_in_execute", {29'd0, state_out}, 32'd2);
        chk("pre_reset_flags", {28'd0, flags_out}, 32'b1000);
        reset = 1'b1;
        #1;
        chk("async_reset_state", {29'd0, state_out}, 32'd0);
        chk("async_reset_pc", {24'd0, pc_out}, 32'd0);
        chk("async_reset_flags", {28'd0, flags_out}, 32'd0);
        chk("async_reset_ir", dut.ir, 32'd0);
        for (int i = 0; i < 16; i++) chk($sformatf("async_reset_r%0d", i), dut.regs_r[i], 32'd0);
        @(posedge clock);
        #1;
        chk("reset_next_state", {29'd0, state_out}, 32'd0);
        chk("reset_next_pc", {24'd0, pc_out}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Multi-cycle, non-pipelined 32-bit load/store CPU with internal instruction ROM, data RAM, register file, ALU and NZCV flags.
- Every instruction is conditional: it executes only when its condition field passes against the current flags.
- Top-level processor of the design. The bench preloads ROM and RAM and observes internal state hierarchically.

Parameters:
- ROM_DEPTH, 256: instruction words; pc width is 8 bits.
- RAM_DEPTH, 16: data words; RAM address uses bits [3:0].
- DATA_W, 32: data and instruction width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_out  output  8  current pc.
- state_out  output  3  current FSM state.
- flags_out  output  4  NZCV flags.

Behaviour:
- Memories:
  - Internal instance "rom": array "mem", ROM_DEPTH×32, read-only, asynchronous read.
  - Internal instance "ram": array "mem", RAM_DEPTH×32, synchronous write, asynchronous read.
  - Both arrays are loaded externally via $readmem*.
  - Reset does not clear either memory.
- Register file: R0–R15, 32 bits each. All registers reset to 0.
- Instruction format:
  - [31:28] cond
  - [27:24] opcode
  - [23:20] dest
  - [19:16] select1
  - [15:12] select2
  - [11:0] imm12, zero-extended
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(src1).
  - 6 LSL and 7 LSR: src1 shifted by src2[4:0].
  - 8 MOV: dest←src2. 9 MOVI: dest←imm.
  - A LOAD: dest←RAM[(src1+imm)[3:0]].
  - B STORE: RAM[(src1+imm)[3:0]]←src2.
  - C CMP: SUB that updates flags only.
  - D B: pc←imm[7:0].
  - E NOP.
  - F HALT: stay in HALT until reset.
- Condition codes:
  - 0 AL, 1 EQ(Z), 2 NE, 3 CS(C), 4 CC, 5 MI(N), 6 PL, 7 VS(V), 8 VC.
  - 9–F never execute.
  - Internal signal "execute" = 1 when cond passes.
- FSM states (3 bits), each one cycle:
  - FETCH=0: latch ir←rom[pc].
  - DECODE=1: read source1 and source2 from the register file; evaluate execute.
  - EXECUTE=2: ALU computes ALU_data.
  - MEM=3: LOAD/STORE RAM access; other opcodes pass through.
  - WRITEBACK=4: register write, flag update, pc update; return to FETCH.
  - HALT=5.
- Every instruction takes 5 cycles.
- Not-executed instruction: still takes 5 cycles; no register, RAM or flag writes; pc←pc+1.
- pc update: normally pc+1 with 8-bit wrap (255→0). Executed B loads imm[7:0].
- Flags update only for executed ADD, SUB, CMP and logical ops (AND, OR, XOR, NOT, LSL, LSR).
  - N = result[31].
  - Z = (result == 0).
  - C = carry out for ADD; no-borrow (src1 ≥ src2 unsigned) for SUB/CMP.
  - V = signed overflow for ADD/SUB/CMP.
  - Logical ops: C and V are preserved.
- Arithmetic wraps modulo 2^32. Shift amounts ≥ 32 are impossible (5-bit).
- Reset (asynchronous, any state including mid-instruction): state=FETCH, pc=0, flags=0000, ir=0, registers=0. An in-progress STORE is aborted.
- STORE is written only in MEM while execute=1. Writes to R0 are allowed (R0 is not hard-wired).
- Visible internal signals: current_state, pc, opcode, cond, select1, select2, dest, source1, source2, ALU_data, flags, execute.

Decomposition:
- Package cpu_pkg: opcode constants, condition-code constants, FSM state encoding, field bit positions.
- One sub-module cpu_alu: inputs a, b, op; outputs result and NZCV.
- Condition check, register file and memories stay in cpu_core.

Test Plan:
- Reset mid-EXECUTE → next cycle state=0, pc=0, flags=0000, registers 0.
- ROM[0]=MOVI R1,#5; ROM[1]=MOVI R2,#3; ROM[2]=ADD R3,R1,R2 → R3=8, flags=0000, pc=3 after 15 cycles.
- CMP R1,R1 then NE-conditional MOVI R4,#7 → Z=1, C=1, execute=0, R4 stays 0, pc still advances.
- RAM[2]=0xDEADBEEF; LOAD R5,[R0+2]; STORE R5 to [R0+15] → R5=0xDEADBEEF, RAM[15]=0xDEADBEEF.
- MOVI R1,#0; SUB R2,R1,#1 via R6=1 → R2=0xFFFFFFFF, flags N=1, Z=0, C=0, V=0.
- B #0 at pc=7 loops to pc=0. HALT holds state=5 and the pc unchanged for 20 cycles.
